// File: rtl/ddr3_iod_delay_tap_ctrl_pkg.sv
// Shared types and constants for the DDR3 IOD delay-tap controller.
package ddr3_iod_dly_pkg;

    localparam int TAP_W_DEF = 8;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DIR,
        S_MOVE,
        S_DONE
    } state_t;

endpackage

// File: rtl/ddr3_iod_delay_tap_ctrl_if.sv
// Request/status bus between the training sequencer and one IOD lane tap controller.
interface ddr3_iod_delay_tap_ctrl_if #(
    parameter int TAP_W = ddr3_iod_dly_pkg::TAP_W_DEF
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [TAP_W-1:0] REQ_TAP;
    logic             REQ_LOAD;
    logic             ERR_CLR;
    logic             DONE;
    logic [TAP_W-1:0] TAP_CUR;
    logic             ERR_OOR;

    modport master (
        output REQ_VALID, REQ_TAP, REQ_LOAD, ERR_CLR,
        input  REQ_READY, DONE, TAP_CUR, ERR_OOR
    );

    modport slave (
        input  REQ_VALID, REQ_TAP, REQ_LOAD, ERR_CLR,
        output REQ_READY, DONE, TAP_CUR, ERR_OOR
    );
endinterface

// File: rtl/ddr3_iod_settle_timer.sv
// Loadable 4-bit down-counter; expired is high once the settle window has elapsed.
module ddr3_iod_settle_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic expired
);
    // Loading S-1 makes expired assert on the S-th cycle after start.
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYC - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start)
            cnt <= LOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - 4'd1;
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/ddr3_iod_delay_tap_ctrl.sv
// Steps one IOD delay line to a requested tap, one MOVE at a time, with settle gaps.
// Optional IOD_EYE_CLR_EN: pulse EYE_MONITOR_CLEAR_FLAGS_0 on error-free completion.
module ddr3_iod_delay_tap_ctrl
    import ddr3_iod_dly_pkg::*;
#(
    parameter int TAP_W      = TAP_W_DEF,
    parameter int INIT_TAP   = 1,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 4
) (
    input  logic FAB_CLK,
    input  logic ARST_N,
    ddr3_iod_delay_tap_ctrl_if.slave req,
    output logic DELAY_LINE_LOAD_0,
    output logic DELAY_LINE_MOVE_0,
    output logic DELAY_LINE_DIRECTION_0,
    input  logic DELAY_LINE_OUT_OF_RANGE_0,
    output logic EYE_MONITOR_CLEAR_FLAGS_0
);
    localparam logic [TAP_W-1:0] INIT_V = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] MAX_V  = TAP_W'(MAX_TAP);

    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] t);
        return (t > MAX_V) ? MAX_V : t;
    endfunction

    state_t           state, next;
    logic [TAP_W-1:0] target, tap;
    logic             ready, done, err, load, move, dir;
    logic             settle_done, settle_start, set_err;

    ddr3_iod_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
        .clk     (FAB_CLK),
        .rst_n   (ARST_N),
        .start   (settle_start),
        .expired (settle_done)
    );

    assign settle_start = (next == S_SETTLE) && (state != S_SETTLE);

    always_comb begin
        next    = state;
        set_err = 1'b0;
        case (state)
            S_IDLE:   if (req.REQ_VALID) next = req.REQ_LOAD ? S_LOAD : S_SETTLE;
            S_LOAD:   next = S_SETTLE;
            S_SETTLE: begin
                if (settle_done) begin
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        set_err = 1'b1;
                        next    = S_DONE;
                    end else if (tap == target) begin
                        next = S_DONE;
                    end else begin
                        next = S_DIR;
                    end
                end
            end
            S_DIR:    next = S_MOVE;
            S_MOVE:   next = S_SETTLE;
            S_DONE:   next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    // Target is only meaningful after acceptance, so it carries no reset.
    always_ff @(posedge FAB_CLK) begin
        if (state == S_IDLE && req.REQ_VALID)
            target <= clamp_tap(req.REQ_TAP);
    end

    // Outputs are decoded from next state so they are registered yet coincide with the state.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= S_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            tap   <= INIT_V;
            err   <= 1'b0;
            load  <= 1'b0;
            move  <= 1'b0;
            dir   <= DIR_DEC;
        end else begin
            state <= next;
            ready <= (next == S_IDLE);
            done  <= (next == S_DONE);
            load  <= (next == S_LOAD);
            move  <= (next == S_MOVE);
            if (next == S_LOAD)
                tap <= INIT_V;
            else if (next == S_MOVE)
                tap <= (dir == DIR_INC) ? tap + 1'b1 : tap - 1'b1;
            if (next == S_DIR)
                dir <= (target > tap) ? DIR_INC : DIR_DEC;
            if (set_err)
                err <= 1'b1;
            else if (state == S_IDLE && req.ERR_CLR)
                err <= 1'b0;
        end
    end

`ifdef IOD_EYE_CLR_EN
    logic eye;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N)
            eye <= 1'b0;
        else
            eye <= (next == S_DONE) && !err && !set_err;
    end

    assign EYE_MONITOR_CLEAR_FLAGS_0 = eye;
`else
    assign EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;
`endif

    assign req.REQ_READY          = ready;
    assign req.DONE               = done;
    assign req.TAP_CUR            = tap;
    assign req.ERR_OOR            = err;
    assign DELAY_LINE_LOAD_0      = load;
    assign DELAY_LINE_MOVE_0      = move;
    assign DELAY_LINE_DIRECTION_0 = dir;
endmodule

// File: tb/tb_ddr3_iod_delay_tap_ctrl.sv
// Directed bench for ddr3_iod_delay_tap_ctrl with default parameters (S=4, INIT_TAP=1, MAX_TAP=127).
module tb_ddr3_iod_delay_tap_ctrl;
    logic FAB_CLK = 1'b0;
    logic ARST_N  = 1'b0;
    logic load_o, move_o, dir_o, eye_o;
    logic oor = 1'b0;
    int checks = 0;
    int errors = 0;

`ifdef IOD_EYE_CLR_EN
    localparam int EYE_EXP = 1;
`else
    localparam int EYE_EXP = 0;
`endif

    ddr3_iod_delay_tap_ctrl_if #(.TAP_W(8)) req_bus ();

    ddr3_iod_delay_tap_ctrl dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .req                       (req_bus.slave),
        .DELAY_LINE_LOAD_0         (load_o),
        .DELAY_LINE_MOVE_0         (move_o),
        .DELAY_LINE_DIRECTION_0    (dir_o),
        .DELAY_LINE_OUT_OF_RANGE_0 (oor),
        .EYE_MONITOR_CLEAR_FLAGS_0 (eye_o)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Issues one request (accepted in cycle 0) and observes it until DONE or a cycle budget.
    task automatic run_req(input int tap, input bit ld, input int oor_after, input bit poke,
                           output int done_cyc, output int load_cyc, output int moves,
                           output int ups, output int busy_rdy, output int eye_seen,
                           output int rdy_after);
        done_cyc = -1; load_cyc = -1; moves = 0; ups = 0;
        busy_rdy = 0; eye_seen = 0; rdy_after = 0;
        @(negedge FAB_CLK);
        req_bus.REQ_VALID = 1'b1;
        req_bus.REQ_TAP   = 8'(tap);
        req_bus.REQ_LOAD  = ld;
        @(posedge FAB_CLK);
        #1;
        req_bus.REQ_VALID = 1'b0;
        req_bus.REQ_LOAD  = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge FAB_CLK);
            if (req_bus.REQ_READY) busy_rdy++;
            if (load_o) load_cyc = cyc;
            if (eye_o) eye_seen++;
            if (move_o) begin
                moves++;
                ups += int'(dir_o);
                if (moves == oor_after) oor = 1'b1;
            end
            if (poke && cyc == 5) begin
                req_bus.REQ_VALID = 1'b1;
                req_bus.REQ_TAP   = 8'd5;
            end
            if (poke && cyc == 8) req_bus.REQ_VALID = 1'b0;
            if (req_bus.DONE) begin
                done_cyc = cyc;
                break;
            end
            @(posedge FAB_CLK);
        end
        @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        rdy_after = int'(req_bus.REQ_READY);
    endtask

    int dc, lc, mv, up, br, ey, ra, extra;
    bit moved;

    initial begin
        req_bus.REQ_VALID = 1'b0;
        req_bus.REQ_TAP   = '0;
        req_bus.REQ_LOAD  = 1'b0;
        req_bus.ERR_CLR   = 1'b0;

        #12;
        chk("rst_ready", int'(req_bus.REQ_READY), 1);
        chk("rst_done",  int'(req_bus.DONE), 0);
        chk("rst_tap",   int'(req_bus.TAP_CUR), 1);
        chk("rst_err",   int'(req_bus.ERR_OOR), 0);
        chk("rst_ldmv",  int'({load_o, move_o, dir_o, eye_o}), 0);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);

        // Step up 1 -> 4: DONE at 4 + 3*6 + 1 = 23.
        run_req(4, 1'b0, 0, 1'b0, dc, lc, mv, up, br, ey, ra);
        chk("up_done_cyc", dc, 23);
        chk("up_moves",    mv, 3);
        chk("up_dir_inc",  up, 3);
        chk("up_tap",      int'(req_bus.TAP_CUR), 4);
        chk("up_busy_rdy", br, 0);
        chk("up_rdy_after", ra, 1);
        chk("up_eye",      ey, EYE_EXP);
        chk("up_noload",   lc, -1);

        // Step down 4 -> 2: DONE at 4 + 2*6 + 1 = 17.
        run_req(2, 1'b0, 0, 1'b0, dc, lc, mv, up, br, ey, ra);
        chk("dn_done_cyc", dc, 17);
        chk("dn_moves",    mv, 2);
        chk("dn_dir_inc",  up, 0);
        chk("dn_tap",      int'(req_bus.TAP_CUR), 2);

        // Load to INIT_TAP = 1 from 2: LOAD in cycle 1, DONE in cycle 6.
        run_req(1, 1'b1, 0, 1'b0, dc, lc, mv, up, br, ey, ra);
        chk("ld_load_cyc", lc, 1);
        chk("ld_done_cyc", dc, 6);
        chk("ld_moves",    mv, 0);
        chk("ld_tap",      int'(req_bus.TAP_CUR), 1);
        chk("ld_eye",      ey, EYE_EXP);

        // Out of range after 2nd MOVE: 1 -> 3, DONE at 4 + 2*6 + 1 = 17.
        run_req(10, 1'b0, 2, 1'b0, dc, lc, mv, up, br, ey, ra);
        chk("oor_done_cyc", dc, 17);
        chk("oor_moves",    mv, 2);
        chk("oor_tap",      int'(req_bus.TAP_CUR), 3);
        chk("oor_err",      int'(req_bus.ERR_OOR), 1);
        chk("oor_eye",      ey, 0);
        oor = 1'b0;
        @(negedge FAB_CLK);
        req_bus.ERR_CLR = 1'b1;
        @(posedge FAB_CLK);
        #1;
        req_bus.ERR_CLR = 1'b0;
        @(negedge FAB_CLK);
        chk("errclr", int'(req_bus.ERR_OOR), 0);

        // Clamp 200 -> 127 from 3 with a busy-time request: DONE at 4 + 124*6 + 1 = 749.
        run_req(200, 1'b0, 0, 1'b1, dc, lc, mv, up, br, ey, ra);
        chk("clamp_done_cyc", dc, 749);
        chk("clamp_moves",    mv, 124);
        chk("clamp_tap",      int'(req_bus.TAP_CUR), 127);
        extra = 0;
        repeat (20) begin
            @(negedge FAB_CLK);
            if (req_bus.DONE || move_o) extra++;
        end
        chk("busy_req_ignored", extra, 0);
        chk("busy_tap_hold",    int'(req_bus.TAP_CUR), 127);

        // Asynchronous reset in the middle of a MOVE cycle.
        @(negedge FAB_CLK);
        req_bus.REQ_VALID = 1'b1;
        req_bus.REQ_TAP   = 8'd10;
        @(posedge FAB_CLK);
        #1;
        req_bus.REQ_VALID = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge FAB_CLK);
            if (move_o) begin
                moved = 1'b1;
                break;
            end
        end
        chk("mid_move_seen", int'(moved), 1);
        ARST_N = 1'b0;
        #1;
        chk("mid_rst_ready", int'(req_bus.REQ_READY), 1);
        chk("mid_rst_tap",   int'(req_bus.TAP_CUR), 1);
        chk("mid_rst_done",  int'(req_bus.DONE), 0);
        chk("mid_rst_ctl",   int'({load_o, move_o, dir_o, eye_o, req_bus.ERR_OOR}), 0);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        chk("post_rst_idle", int'(req_bus.REQ_READY), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr3_iod_delay_tap_ctrl.md
# ddr3_iod_delay_tap_ctrl

Per-lane delay-tap controller for the DDR3 PHY address/command IODs. Sits directly upstream of one IOD lane (e.g. A12). Accepts a target delay tap from the training sequencer and steps the IOD delay line to it, one tap at a time, using the DELAY_LINE_LOAD/MOVE/DIRECTION controls. It tracks the current tap and reports delay-line out-of-range errors.

## Interface
Parameters:
- TAP_W, 8: width of tap values.
- INIT_TAP, 1: tap value after reset or LOAD; equals the IOD static delay value.
- MAX_TAP, 127: largest legal tap. Requests above it are clamped.
- SETTLE_CYC, 4: settle cycles after every LOAD/MOVE pulse. Legal range 1..15.

Ports:
- FAB_CLK  in  1  fabric clock, shared with the IOD TX/RX_CLK.
- ARST_N  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  1  tap request valid.
- REQ_READY  out  1  controller idle, can accept a request.
- REQ_TAP  in  TAP_W  target tap.
- REQ_LOAD  in  1  with the request: reload INIT_TAP before stepping.
- ERR_CLR  in  1  clears ERR_OOR; honoured in IDLE only.
- DONE  out  1  one-cycle completion pulse.
- TAP_CUR  out  TAP_W  current tap.
- ERR_OOR  out  1  sticky out-of-range flag.
- DELAY_LINE_LOAD_0  out  1  to IOD.
- DELAY_LINE_MOVE_0  out  1  to IOD.
- DELAY_LINE_DIRECTION_0  out  1  to IOD; 1 = increment.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from IOD.
- EYE_MONITOR_CLEAR_FLAGS_0  out  1  to IOD.

## Operation
- FSM states: IDLE, LOAD, SETTLE, DIR, MOVE, DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID: latch target = min(REQ_TAP, MAX_TAP).
  - If REQ_LOAD=1, go to LOAD; otherwise go to SETTLE.
  - ERR_CLR clears ERR_OOR.
- LOAD: DELAY_LINE_LOAD_0=1 for one cycle, TAP_CUR<=INIT_TAP, then go to SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles.
  - On the last cycle, check in this order:
    - If DELAY_LINE_OUT_OF_RANGE_0=1: set ERR_OOR and go to DONE.
    - Else if TAP_CUR==target: go to DONE.
    - Else go to DIR.
- DIR:
  - DIRECTION <= (target>TAP_CUR).
  - DIRECTION is held from DIR through the following MOVE.
- MOVE:
  - DELAY_LINE_MOVE_0=1 for one cycle.
  - TAP_CUR increments or decrements by 1.
  - Then go to SETTLE.
- DONE: DONE=1 for one cycle, then go to IDLE.
- TAP_CUR never leaves 0..MAX_TAP: target is clamped, and stepping stops on equality.
- After an error, TAP_CUR holds the last stepped value and no further MOVE is issued.
- REQ_VALID outside IDLE is ignored. The requester holds REQ_VALID until REQ_READY is high.
- ERR_CLR outside IDLE is ignored.

## Timing
- Reset values: REQ_READY=1, DONE=0, TAP_CUR=INIT_TAP, ERR_OOR=0, all DELAY_LINE_* outputs=0, EYE_MONITOR_CLEAR_FLAGS_0=0, FSM=IDLE.
- Reset applies immediately, including mid-MOVE. The IOD shares ARST_N, so its tap reverts to INIT_TAP as well.
- All outputs are registered.
- Request accepted in cycle 0, N = |target − start tap|, S = SETTLE_CYC:
  - No load: DONE in cycle S+N·(S+2)+1.
  - With load: DONE one cycle later. N is counted from INIT_TAP, LOAD pulses in cycle 1.
- REQ_READY is low from cycle 1 through the DONE cycle, and high the cycle after DONE.
- A request presented in that cycle is accepted.
- MOVE pulses are at least S+2 cycles apart.

## Configuration
- Macro IOD_EYE_CLR_EN.
- Defined: EYE_MONITOR_CLEAR_FLAGS_0 pulses in the DONE cycle when ERR_OOR=0, so the eye-monitor flags restart at the new tap.
- Undefined: EYE_MONITOR_CLEAR_FLAGS_0 is tied to 0 and the port remains.

## Structure
- Package ddr3_iod_dly_pkg holds:
  - the state enum;
  - DIR_INC=1'b1 and DIR_DEC=1'b0;
  - the default TAP_W.
- One sub-module: ddr3_iod_settle_timer.
  - Loadable down-counter of 4 bits.
  - Start input, `expired` output.
  - Instantiated once for SETTLE.

## Test plan
- Reset check: assert ARST_N low mid-operation → all outputs at reset values in the same cycle, TAP_CUR=1, REQ_READY=1.
- Step up: S=4, from tap 1, request REQ_TAP=4, no load → 3 MOVE pulses with DIRECTION=1, DONE in cycle 23, TAP_CUR=4. With IOD_EYE_CLR_EN, EYE_MONITOR_CLEAR_FLAGS_0 also pulses in cycle 23.
- Step down: then request REQ_TAP=2 → 2 MOVE pulses with DIRECTION=0, TAP_CUR=2, DONE in cycle 17.
- Load: request REQ_TAP=1 with REQ_LOAD=1 from tap 2 → LOAD pulse in cycle 1, no MOVE, DONE in cycle 6, TAP_CUR=1.
- Out of range: request REQ_TAP=10, force OUT_OF_RANGE=1 after the 2nd MOVE → DONE with ERR_OOR=1, TAP_CUR=3, no further MOVE, no eye-clear. ERR_CLR in IDLE → ERR_OOR=0.
- Clamp and busy: request REQ_TAP=200 → TAP_CUR ends at 127. A second REQ_VALID while busy is ignored.
